// File: rtl/fire_pkg.sv
// Shared constants and types for the (64,40) Fire code encode and decode paths.
// g(x) = (x^15+1)(x^9+x^4+1); polynomials omit their leading term.
package fire_pkg;

  localparam int FIRE_N = 64;
  localparam int FIRE_K = 40;
  localparam int FIRE_R = FIRE_N - FIRE_K;

  localparam int FIRE_C_DEG = 15;
  localparam int FIRE_P_DEG = 9;
  localparam logic [FIRE_P_DEG-1:0] FIRE_P_POLY = 9'h011;
  localparam logic [FIRE_R-1:0] FIRE_G_POLY = 24'h088211;
  localparam int FIRE_PERIOD = 7665;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fire_state_e;

endpackage

// File: rtl/fire_encoder_if.sv
// Message-in / codeword-out handshake bundle for the Fire encoder.
// Both channels: a transfer happens on a rising clk edge where valid & ready are both high;
// the producer holds valid and data stable until that edge, and ready never depends on valid.
interface fire_encoder_if
  import fire_pkg::*;
#(
    parameter int N = FIRE_N,
    parameter int K = FIRE_K
);

    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_msg;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_code;

    modport master(
        output in_valid, in_msg, out_ready,
        input  in_ready, out_valid, out_code
    );

    modport slave(
        input  in_valid, in_msg, out_ready,
        output in_ready, out_valid, out_code
    );

endinterface

// File: rtl/fire_lfsr.sv
// R-bit Galois divider: shifts din into a remainder modulo x^R + POLY, one bit per enabled cycle.
// rem_nxt_o exposes the value the next enabled edge will load, so callers can capture it early.
module fire_lfsr #(
    parameter int           R    = 24,
    parameter logic [R-1:0] POLY = 24'h088211
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         din_i,
    output logic [R-1:0] rem_o,
    output logic [R-1:0] rem_nxt_o
);

    logic [R-1:0] rem_q;
    logic         fb;

    assign fb        = din_i ^ rem_q[R-1];
    assign rem_nxt_o = {rem_q[R-2:0], 1'b0} ^ (fb ? POLY : '0);
    assign rem_o     = rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
        end else if (clr_i) begin
            rem_q <= '0;
        end else if (en_i) begin
            rem_q <= rem_nxt_o;
        end
    end

endmodule

// File: rtl/fire_encoder.sv
// Bit-serial systematic Fire encoder: latches a K-bit message, divides it by g(x) over K cycles,
// then presents {message, parity} until the downstream accepts it.
module fire_encoder
  import fire_pkg::*;
#(
    parameter int               N      = FIRE_N,
    parameter int               K      = FIRE_K,
    parameter logic [N-K-1:0]   G_POLY = FIRE_G_POLY
) (
    input  logic           clk,
    input  logic           rst,
    fire_encoder_if.slave  bus,
    output logic           busy,
    output fire_state_e    dbg_state_o
);

    localparam int R  = N - K;
    localparam int CW = 6;

    fire_state_e  state_q, state_d;
    logic [K-1:0] msg_q, msg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] code_q, code_d;

    logic         lfsr_clr;
    logic         lfsr_en;
    logic         lfsr_din;
    logic [R-1:0] rem;
    logic [R-1:0] rem_nxt;
    logic [CW-1:0] bit_idx;

    // Message is fed most-significant coefficient first.
    assign bit_idx  = CW'(K - 1) - cnt_q;
    assign lfsr_din = msg_q[bit_idx];

    fire_lfsr #(
        .R   (R),
        .POLY(G_POLY)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (lfsr_clr),
        .en_i     (lfsr_en),
        .din_i    (lfsr_din),
        .rem_o    (rem),
        .rem_nxt_o(rem_nxt)
    );

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        lfsr_clr = 1'b0;
        lfsr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = SHIFT;
                    msg_d    = bus.in_msg;
                    cnt_d    = '0;
                    lfsr_clr = 1'b1;
                end
            end
            SHIFT: begin
                lfsr_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    state_d = DONE;
                    // Capture the final remainder on the DONE entry edge so the output holds still.
                    code_d  = {msg_q, rem_nxt};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            msg_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_code  = code_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state_o   = state_q;

    logic unused_rem;
    assign unused_rem = ^rem;

endmodule

// File: tb/tb_fire_encoder.sv
// Directed and random checks of the Fire encoder against an independent long-division model.
module tb_fire_encoder;
  import fire_pkg::*;

  localparam logic [63:0] G_FULL = 64'h0000_0000_0108_8211;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  fire_state_e dbg_state;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fire_encoder_if bus ();

  fire_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] mod_g(input logic [63:0] c);
    logic [63:0] r;
    r = c;
    for (int i = 63; i >= 24; i--) begin
      if (r[i]) r = r ^ (G_FULL << (i - 24));
    end
    return r[23:0];
  endfunction

  function automatic logic [63:0] model_code(input logic [39:0] m);
    return {m, mod_g({m, 24'h0})};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one message; returns right after the accepting edge.
  task automatic send(input logic [39:0] m, input logic [63:0] e, input bit push);
    int w;
    logic rdy;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_msg   = m;
    if (push) exp_q.push_back(e);
    do begin
      rdy = bus.in_ready;
      tick();
      w++;
    end while (!rdy && w < 200);
    if (!rdy) check("accept_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: pop on every completed output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("code", bus.out_code, e);
        check("mod_g", 64'(mod_g(bus.out_code)), 64'd0);
      end
    end
  end

  initial begin
    int w;
    logic [39:0] m;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_msg    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_code", bus.out_code, 64'd0);
    tick();

    // Zero message and latency.
    bus.out_ready = 1'b1;
    send(40'h0, 64'h0000000000000000, 1'b1);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
    w = 0;
    while (!bus.out_valid && w < 100) begin
      tick();
      w++;
    end
    check("latency", 64'(w), 64'd40);
    tick();

    send(40'h0000000001, 64'h0000000001088211, 1'b1);
    send(40'h0000000002, 64'h0000000002110422, 1'b1);
    send(40'h0000000003, 64'h0000000003198633, 1'b1);

    // Backpressure with a pending request.
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    bus.out_ready = 1'b0;
    send(40'h0000000001, 64'h0000000001088211, 1'b1);
    w = 0;
    while (!bus.out_valid && w < 100) begin
      tick();
      w++;
    end
    check("bp_latency", 64'(w), 64'd40);
    bus.in_valid = 1'b1;
    bus.in_msg   = 40'h0000000002;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_code", bus.out_code, 64'h0000000001088211);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    check("bp_state", 64'(dbg_state), 64'(DONE));
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    send(40'h0000000002, 64'h0000000002110422, 1'b1);
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset in the middle of SHIFT discards the word.
    send(40'hAB_CDEF_0123, 64'h0, 1'b0);
    repeat (19) tick();
    check("mid_shift_state", 64'(dbg_state), 64'(SHIFT));
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_out_code", bus.out_code, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid) check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      tick();
    end
    send(40'h0000000003, 64'h0000000003198633, 1'b1);

    // Random back-to-back traffic.
    for (int i = 0; i < 1000; i++) begin
      m = {8'($urandom_range(0, 255)), 32'($urandom())};
      send(m, model_code(m), 1'b1);
    end
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    check("final_drain", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(bus.in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fire_encoder.md
# fire_encoder

Bit-serial systematic encoder for the shortened (64,40) Fire code used across the design. It accepts a 40-bit message over a valid/ready handshake and divides it by the generator g(x) = (x^15+1)(x^9+x^4+1) in a 24-bit LFSR, one bit per cycle. It emits the 64-bit codeword {message, parity} over a second valid/ready handshake. It is the transmit-side producer of the codewords the Fire decode path consumes, and it replaces ad-hoc parity generation in the controller.

## Interface

- N, 64: codeword width.
- K, 40: message width. R = N-K = 24 is a derived localparam, not overridable.
- G_POLY, 24'h088211: g(x) without its x^24 term, where bit i is the coefficient of x^i.

Ports, clock and reset first:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_msg is valid.
- in_ready  output  1  block can accept a message.
- in_msg  input  K  message; in_msg[K-1] is the highest-degree coefficient.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  downstream accepts out_code.
- out_code  output  N  codeword; out_code[N-1:R] = message, out_code[R-1:0] = parity.
- busy  output  1  high in SHIFT or DONE.

## Operation

- States:
  - IDLE: in_ready=1.
  - SHIFT: processes K bits.
  - DONE: out_valid=1.
- IDLE → SHIFT on in_valid & in_ready.
  - Latch in_msg into msg_reg.
  - Clear rem to 0.
  - Clear bit counter cnt (6 bits) to 0.
- SHIFT, each cycle:
  - b = msg_reg[K-1-cnt]; fb = b ^ rem[R-1].
  - rem <= {rem[R-2:0],1'b0} ^ (fb ? G_POLY : 0).
  - cnt <= cnt+1.
  - When cnt == K-1, the update is applied and the state goes to DONE.
- DONE:
  - out_code = {msg_reg, rem}, held stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE.
- in_valid in SHIFT or DONE is ignored, because in_ready=0. Upstream holds it.
- Every out_code, read as a polynomial of degree < 64, is divisible by g(x).
- Reset, including mid-SHIFT or mid-DONE: the state returns to IDLE, the in-flight word is discarded, and no out_valid is produced for it.
- Reset values: in_ready=1, out_valid=0, busy=0, out_code=0, msg_reg=0, rem=0, cnt=0.

## Timing

- Accept edge T0 (in_valid & in_ready sampled high): in_ready drops after T0.
- SHIFT occupies edges T1..T40. out_valid rises after T40, which is 40 cycles after accept.
- Output handshake completes at the first edge with out_valid & out_ready. out_valid drops and in_ready rises after that edge.
- The earliest next accept is the following edge. Throughput is one word per 42 cycles when out_ready is held high.
- in_ready and out_valid are registered-state decodes. There is no combinational path from in_valid or out_ready to any output.
- out_code changes only on the DONE entry edge and on reset.

## Structure

- Shared package fire_pkg holds:
  - FIRE_N=64, FIRE_K=40, FIRE_R=24.
  - FIRE_C_DEG=15, FIRE_P_DEG=9.
  - FIRE_P_POLY=9'h011 (x^9+x^4+1 without x^9).
  - FIRE_G_POLY=24'h088211.
  - FIRE_PERIOD=7665.
  - State enum {IDLE, SHIFT, DONE}.
  The decode path imports the same constants.
- One sub-module, fire_lfsr: an R-bit Galois divider with inputs clr, en, din and output rem, parameterised by the polynomial. It is reusable by the decoder's syndrome stage.
- The FSM, counter and handshake live in fire_encoder.

## Test plan

- in_msg=40'h0, out_ready=1 → out_code=64'h0000000000000000, out_valid exactly 40 cycles after accept.
- in_msg=40'h0000000001 → out_code=64'h0000000001088211. in_msg=40'h0000000002 → 64'h0000000002110422.
- Linearity: in_msg=40'h0000000003 → 64'h0000000003198633 (the XOR of the previous two codewords).
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_code and out_valid stay stable, in_ready=0, and a pending in_valid is not accepted. Releasing out_ready gives in_ready=1 the next cycle.
- Reset asserted at cycle 20 of SHIFT → outputs reach reset values asynchronously and no out_valid follows. The next message encodes correctly.
- 1000 random messages, back-to-back → every out_code[63:24] equals in_msg, a software mod-g(x) check gives remainder 0, and the decoder returns in_msg unchanged.
